// File: rtl/Stump_definitions.sv
// Shared Stump encodings: control-decoder state codes and the opcodes the
// sequencer needs to look at.
package Stump_definitions;

    localparam logic [1:0] FETCH   = 2'b00;
    localparam logic [1:0] EXECUTE = 2'b01;
    localparam logic [1:0] MEMORY  = 2'b10;

    localparam logic [2:0] LDST = 3'b011;
    localparam logic [2:0] BCC  = 3'b111;

endpackage

// File: rtl/stump_sequencer_pkg.sv
// Sequencer-local types: the internal state set (which adds HALT to the
// decoder-visible states) and small elaboration helpers.
package stump_sequencer_pkg;

    import Stump_definitions::*;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } seq_state_e;

    // HALT looks like FETCH to the decoder; commit is what keeps it inert.
    function automatic logic [1:0] state_code(input seq_state_e s);
        case (s)
            S_EXEC:  return EXECUTE;
            S_MEM:   return MEMORY;
            default: return FETCH;
        endcase
    endfunction

    // The wait counter only ever needs to reach MAX_WAIT-1.
    function automatic int unsigned wait_width(input int unsigned max_wait);
        return (max_wait < 2) ? 1 : $clog2(max_wait);
    endfunction

endpackage

// File: rtl/stump_wait_timer.sv
// Counts consecutive memory-wait cycles and flags the cycle on which the
// MAX_WAIT-th consecutive wait is being spent. MAX_WAIT == 0 never expires.
module stump_wait_timer
    import stump_sequencer_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    generate
        if (MAX_WAIT == 0) begin : g_disabled
            wire unused_timer_inputs = ^{clk, srst, clear, tick};
            assign expired = 1'b0;
        end else begin : g_enabled
            localparam int unsigned CW = wait_width(MAX_WAIT);
            localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

            logic [CW-1:0] count_reg;
            logic [CW-1:0] count_next;

            // Expiry is combinational so the sequencer leaves on this edge.
            assign expired = tick && (count_reg == LAST);

            // Clear wins over tick: a completed access or state change restarts the count.
            always_comb begin
                count_next = count_reg;
                if (clear) begin
                    count_next = '0;
                end else if (tick) begin
                    count_next = count_reg + 1'b1;
                end
            end

            // Wait counter register.
            always_ff @(posedge clk) begin
                if (srst) begin
                    count_reg <= '0;
                end else begin
                    count_reg <= count_next;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/stump_sequencer.sv
// Stump cycle sequencer: FETCH/EXECUTE/MEMORY stepping with memory-ready
// stretching, halt/single-step debug, wait timeout and activity counters.
module stump_sequencer
    import Stump_definitions::*;
    import stump_sequencer_pkg::*;
#(
    parameter int          CNT_W        = 16,
    parameter int unsigned MAX_WAIT     = 15,
    parameter bit          RESET_HALTED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       ir_opcode,
    input  logic             mem_ready,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             clr_err,
    output logic [1:0]       state,
    output logic             commit,
    output logic             ir_load,
    output logic             halted,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    localparam seq_state_e RESET_STATE = RESET_HALTED ? S_HALT : S_FETCH;

    seq_state_e       state_reg;
    seq_state_e       state_next;
    logic             step_pending_reg;
    logic             step_pending_next;
    logic             bus_error_reg;
    logic             bus_error_next;
    logic [CNT_W-1:0] instr_count_reg;
    logic [CNT_W-1:0] cycle_count_reg;

    logic             boundary;
    logic             mem_wait;
    logic             timer_clear;
    logic             timer_expired;

    // A wait cycle is any FETCH/MEM cycle where memory has not answered.
    assign mem_wait    = ((state_reg == S_FETCH) || (state_reg == S_MEM)) && !mem_ready;
    assign timer_clear = mem_ready || (state_next != state_reg);

    stump_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .srst    (rst),
        .clear   (timer_clear),
        .tick    (mem_wait),
        .expired (timer_expired)
    );

    // Next-state, commit/ir_load and instruction-boundary decode.
    always_comb begin
        state_next        = state_reg;
        step_pending_next = step_pending_reg;
        bus_error_next    = bus_error_reg;
        commit            = 1'b0;
        ir_load           = 1'b0;
        boundary          = 1'b0;

        case (state_reg)
            S_FETCH: begin
                commit  = mem_ready;
                ir_load = mem_ready;
                if (mem_ready) begin
                    state_next = S_EXEC;
                end else if (timer_expired) begin
                    // Faulted fetch never commits; the PC is left untouched.
                    state_next        = S_HALT;
                    bus_error_next    = 1'b1;
                    step_pending_next = 1'b0;
                end
            end
            S_EXEC: begin
                commit = 1'b1;
                if (ir_opcode == LDST) begin
                    state_next = S_MEM;
                end else begin
                    boundary = 1'b1;
                end
            end
            S_MEM: begin
                commit = mem_ready;
                if (mem_ready) begin
                    boundary = 1'b1;
                end else if (timer_expired) begin
                    state_next        = S_HALT;
                    bus_error_next    = 1'b1;
                    step_pending_next = 1'b0;
                end
            end
            S_HALT: begin
                if (bus_error_reg) begin
                    // A latched fault pins us here until the debugger clears it.
                    if (clr_err) begin
                        bus_error_next = 1'b0;
                    end
                end else if (!halt_req) begin
                    state_next = S_FETCH;
                end else if (step_req) begin
                    state_next        = S_FETCH;
                    step_pending_next = 1'b1;
                end
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Halt requests only take effect between instructions.
        if (boundary) begin
            if (halt_req || step_pending_reg) begin
                state_next        = S_HALT;
                step_pending_next = 1'b0;
            end else begin
                state_next = S_FETCH;
            end
        end

        // Nothing may be written back while reset is held.
        if (rst) begin
            commit  = 1'b0;
            ir_load = 1'b0;
        end
    end

    // State and debug flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= RESET_STATE;
            step_pending_reg <= 1'b0;
            bus_error_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            step_pending_reg <= step_pending_next;
            bus_error_reg    <= bus_error_next;
        end
    end

    // Retired-instruction and active-cycle counters (wrap naturally).
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count_reg <= '0;
            cycle_count_reg <= '0;
        end else begin
            if (boundary) begin
                instr_count_reg <= instr_count_reg + 1'b1;
            end
            if (state_reg != S_HALT) begin
                cycle_count_reg <= cycle_count_reg + 1'b1;
            end
        end
    end

    assign state       = state_code(state_reg);
    assign halted      = (state_reg == S_HALT);
    assign bus_error   = bus_error_reg;
    assign instr_count = instr_count_reg;
    assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_stump_sequencer.sv
// Bench for stump_sequencer: directed vector table, a timeout sequence and a
// randomized run checked against a behavioural instruction-level model.
module tb_stump_sequencer;

    localparam int          CNT_W    = 16;
    localparam int unsigned MAX_WAIT = 15;
    localparam logic [2:0]  OP_ADD   = 3'b000;
    localparam logic [2:0]  OP_LDST  = 3'b011;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       ir_opcode;
    logic             mem_ready;
    logic             halt_req;
    logic             step_req;
    logic             clr_err;
    logic [1:0]       state;
    logic             commit;
    logic             ir_load;
    logic             halted;
    logic             bus_error;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] cycle_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stump_sequencer #(
        .CNT_W        (CNT_W),
        .MAX_WAIT     (MAX_WAIT),
        .RESET_HALTED (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ir_opcode   (ir_opcode),
        .mem_ready   (mem_ready),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .clr_err     (clr_err),
        .state       (state),
        .commit      (commit),
        .ir_load     (ir_load),
        .halted      (halted),
        .bus_error   (bus_error),
        .instr_count (instr_count),
        .cycle_count (cycle_count)
    );

    typedef struct {
        logic       rst;
        logic [2:0] op;
        logic       rdy;
        logic       hreq;
        logic       sreq;
        logic       clr;
        logic [1:0] st;
        logic       cm;
        logic       hl;
        logic       be;
        int         ic;
        int         cc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs after the falling edge and settle before checking.
    task automatic drive(input logic r, input logic [2:0] op, input logic rdy,
                         input logic h, input logic s, input logic c);
        @(negedge clk);
        rst       = r;
        ir_opcode = op;
        mem_ready = rdy;
        halt_req  = h;
        step_req  = s;
        clr_err   = c;
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] st, input logic cm,
                              input logic hl, input logic be, input int ic, input int cc);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".commit"}, 32'(commit), 32'(cm));
        chk({tag, ".halted"}, 32'(halted), 32'(hl));
        chk({tag, ".bus_error"}, 32'(bus_error), 32'(be));
        chk({tag, ".instr_count"}, 32'(instr_count), 32'(ic));
        chk({tag, ".cycle_count"}, 32'(cycle_count), 32'(cc));
    endtask

    task automatic add(input logic r, input logic [2:0] op, input logic rdy, input logic h,
                       input logic s, input logic c, input logic [1:0] st, input logic cm,
                       input logic hl, input logic be, input int ic, input int cc);
        vec_t v;
        v.rst = r; v.op = op; v.rdy = rdy; v.hreq = h; v.sreq = s; v.clr = c;
        v.st = st; v.cm = cm; v.hl = hl; v.be = be; v.ic = ic; v.cc = cc;
        tbl.push_back(v);
    endtask

    // Behavioural model: where the current instruction is (awaiting fetch
    // data, executing, awaiting memory) or parked, plus debug flags.
    bit               m_halted;
    int               m_phase;   // 0 fetch wait, 1 execute, 2 memory wait
    int               m_wait;
    bit               m_step;
    bit               m_err;
    logic [CNT_W-1:0] m_ic;
    logic [CNT_W-1:0] m_cc;

    task automatic model_retire(input logic h);
        m_ic   = m_ic + 1'b1;
        m_wait = 0;
        m_phase = 0;
        if (h || m_step) begin
            m_halted = 1'b1;
            m_step   = 1'b0;
        end
    endtask

    task automatic model_advance(input logic r, input logic [2:0] op, input logic rdy,
                                 input logic h, input logic s, input logic c);
        if (r) begin
            m_halted = 1'b0; m_phase = 0; m_wait = 0; m_step = 1'b0; m_err = 1'b0;
            m_ic = '0; m_cc = '0;
        end else if (m_halted) begin
            if (m_err) begin
                if (c) m_err = 1'b0;
            end else if (!h) begin
                m_halted = 1'b0; m_phase = 0;
            end else if (s) begin
                m_halted = 1'b0; m_phase = 0; m_step = 1'b1;
            end
        end else begin
            m_cc = m_cc + 1'b1;
            if (m_phase == 1) begin
                if (op == OP_LDST) m_phase = 2;
                else model_retire(h);
            end else if (rdy) begin
                m_wait = 0;
                if (m_phase == 0) m_phase = 1;
                else model_retire(h);
            end else begin
                m_wait++;
                if (MAX_WAIT != 0 && m_wait == int'(MAX_WAIT)) begin
                    m_halted = 1'b1; m_err = 1'b1; m_step = 1'b0; m_wait = 0; m_phase = 0;
                end
            end
        end
    endtask

    initial begin
        int         stall_left;
        logic       r_r, rdy_r, h_r, s_r, c_r;
        logic [2:0] op_r;

        rst = 1'b1; ir_opcode = OP_ADD; mem_ready = 1'b0;
        halt_req = 1'b0; step_req = 1'b0; clr_err = 1'b0;

        // Reset state, observed while rst is still held.
        drive(1, OP_ADD, 0, 0, 0, 0);
        drive(1, OP_ADD, 1, 0, 0, 0);
        check_outs("reset", 2'b00, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("reset.ir_load", 32'(ir_load), 32'd0);

        // ADD free run: FETCH/EXECUTE alternate, one instruction per two cycles.
        for (int i = 0; i < 8; i++)
            add(0, OP_ADD, 1, 0, 0, 0, 2'(i % 2), 1, 0, 0, i / 2, i);
        // LDST without and with memory stretch.
        add(0, OP_LDST, 1, 0, 0, 0, 2'd0, 1, 0, 0, 4, 8);
        add(0, OP_LDST, 1, 0, 0, 0, 2'd1, 1, 0, 0, 4, 9);
        add(0, OP_LDST, 1, 0, 0, 0, 2'd2, 1, 0, 0, 4, 10);
        add(0, OP_LDST, 1, 0, 0, 0, 2'd0, 1, 0, 0, 5, 11);
        add(0, OP_LDST, 1, 0, 0, 0, 2'd1, 1, 0, 0, 5, 12);
        add(0, OP_LDST, 0, 0, 0, 0, 2'd2, 0, 0, 0, 5, 13);
        add(0, OP_LDST, 0, 0, 0, 0, 2'd2, 0, 0, 0, 5, 14);
        add(0, OP_LDST, 0, 0, 0, 0, 2'd2, 0, 0, 0, 5, 15);
        add(0, OP_LDST, 1, 0, 0, 0, 2'd2, 1, 0, 0, 5, 16);
        // halt_req raised during a memory wait: the access finishes first.
        add(0, OP_LDST, 1, 0, 0, 0, 2'd0, 1, 0, 0, 6, 17);
        add(0, OP_LDST, 1, 0, 0, 0, 2'd1, 1, 0, 0, 6, 18);
        add(0, OP_LDST, 0, 1, 0, 0, 2'd2, 0, 0, 0, 6, 19);
        add(0, OP_LDST, 0, 1, 0, 0, 2'd2, 0, 0, 0, 6, 20);
        add(0, OP_LDST, 1, 1, 0, 0, 2'd2, 1, 0, 0, 6, 21);
        add(0, OP_ADD,  1, 1, 0, 0, 2'd0, 0, 1, 0, 7, 22);
        add(0, OP_ADD,  1, 1, 0, 0, 2'd0, 0, 1, 0, 7, 22);
        // Single step; halt_req dropped mid-step, the step still re-halts.
        add(0, OP_ADD,  1, 1, 1, 0, 2'd0, 0, 1, 0, 7, 22);
        add(0, OP_ADD,  1, 0, 0, 0, 2'd0, 1, 0, 0, 7, 22);
        add(0, OP_ADD,  1, 0, 0, 0, 2'd1, 1, 0, 0, 7, 23);
        add(0, OP_ADD,  1, 0, 0, 0, 2'd0, 0, 1, 0, 8, 24);
        // step_req while running is ignored.
        add(0, OP_ADD,  1, 0, 1, 0, 2'd0, 1, 0, 0, 8, 24);
        add(0, OP_ADD,  1, 0, 0, 0, 2'd1, 1, 0, 0, 8, 25);
        add(0, OP_ADD,  1, 0, 0, 0, 2'd0, 1, 0, 0, 9, 26);
        // Reset during a memory wait.
        add(0, OP_LDST, 1, 0, 0, 0, 2'd1, 1, 0, 0, 9, 27);
        add(0, OP_LDST, 0, 0, 0, 0, 2'd2, 0, 0, 0, 9, 28);
        add(0, OP_LDST, 0, 0, 0, 0, 2'd2, 0, 0, 0, 9, 29);
        add(1, OP_LDST, 0, 0, 0, 0, 2'd2, 0, 0, 0, 9, 30);
        add(0, OP_ADD,  0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
        add(0, OP_ADD,  1, 0, 0, 0, 2'd0, 1, 0, 0, 0, 1);
        add(0, OP_ADD,  1, 0, 0, 0, 2'd1, 1, 0, 0, 0, 2);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].hreq, tbl[i].sreq, tbl[i].clr);
            check_outs($sformatf("row%0d", i), tbl[i].st, tbl[i].cm, tbl[i].hl, tbl[i].be,
                       tbl[i].ic, tbl[i].cc);
            $display("row %0d: state=%0d commit=%0b halted=%0b bus_error=%0b instr=%0d cycles=%0d",
                     i, state, commit, halted, bus_error, instr_count, cycle_count);
        end

        // Fetch timeout: MAX_WAIT wait cycles, then a sticky bus error in HALT.
        for (int k = 0; k < int'(MAX_WAIT); k++) begin
            drive(0, OP_ADD, 0, 0, 0, 0);
            check_outs($sformatf("tmo_wait%0d", k), 2'd0, 1'b0, 1'b0, 1'b0, 1, 3 + k);
        end
        $display("timeout: %0d fetch wait cycles spent", MAX_WAIT);
        drive(0, OP_ADD, 1, 0, 0, 0);
        check_outs("tmo_fault", 2'd0, 1'b0, 1'b1, 1'b1, 1, 18);
        drive(0, OP_ADD, 1, 0, 0, 0);
        check_outs("tmo_stuck", 2'd0, 1'b0, 1'b1, 1'b1, 1, 18);
        drive(0, OP_ADD, 1, 0, 0, 1);
        check_outs("tmo_clr", 2'd0, 1'b0, 1'b1, 1'b1, 1, 18);
        drive(0, OP_ADD, 1, 0, 0, 0);
        check_outs("tmo_cleared", 2'd0, 1'b0, 1'b1, 1'b0, 1, 18);
        drive(0, OP_ADD, 1, 0, 0, 0);
        check_outs("tmo_refetch", 2'd0, 1'b1, 1'b0, 1'b0, 1, 18);
        chk("tmo_refetch.ir_load", 32'(ir_load), 32'd1);
        drive(0, OP_ADD, 1, 0, 0, 0);
        check_outs("tmo_exec", 2'd1, 1'b1, 1'b0, 1'b0, 1, 19);
        $display("timeout: recovered, instr=%0d cycles=%0d", instr_count, cycle_count);

        // Randomized run against the model; synchronise both with a reset.
        drive(1, OP_ADD, 1, 0, 0, 0);
        model_advance(1, OP_ADD, 1, 0, 0, 0);
        stall_left = 0;
        h_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            logic [1:0] e_st;
            logic       e_cm, e_il;
            r_r  = ($urandom_range(0, 499) == 0);
            op_r = ($urandom_range(0, 2) == 0) ? OP_LDST : 3'($urandom_range(0, 7));
            if (stall_left == 0 && $urandom_range(0, 7) == 0) stall_left = $urandom_range(1, 20);
            rdy_r = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if ($urandom_range(0, 15) == 0) h_r = ~h_r;
            s_r = ($urandom_range(0, 3) == 0);
            c_r = ($urandom_range(0, 5) == 0);
            drive(r_r, op_r, rdy_r, h_r, s_r, c_r);
            e_st = m_halted ? 2'd0 : 2'(m_phase);
            e_cm = !r_r && !m_halted && (m_phase == 1 || rdy_r);
            e_il = !r_r && !m_halted && m_phase == 0 && rdy_r;
            check_outs($sformatf("rnd%0d", i), e_st, e_cm, m_halted, m_err, int'(m_ic), int'(m_cc));
            chk($sformatf("rnd%0d.ir_load", i), 32'(ir_load), 32'(e_il));
            model_advance(r_r, op_r, rdy_r, h_r, s_r, c_r);
        end
        $display("random: 4000 cycles, instr=%0d cycles=%0d", instr_count, cycle_count);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
